// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue stage: loadable program memory issued in order over valid/ready.
// Optional FETCH_LOOP_EN: the program repeats from address 0 until stop.
module instr_fetch_unit #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               start,
    input  logic               stop,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t             state_q;
    logic [ADDR_W:0]    len_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;

    logic [INSTR_W-1:0] mem [DEPTH];

    logic               can_load;
    logic [ADDR_W:0]    len_d;
    logic [ADDR_W-1:0]  pc_d;
    logic [INSTR_W-1:0] first_instr;
    logic               xfer;
    logic               last;

    assign can_load    = load_en && (state_q != RUN);
    assign len_d       = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign pc_d        = pc_q + 1'b1;
    // A load to address 0 on the start cycle must be what gets issued first.
    assign first_instr = (load_en && load_addr == '0) ? load_data : mem[0];
    assign xfer        = valid_q && instr_ready;
    assign last        = ({1'b0, pc_q} == (len_q - 1'b1));

    // Program storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (can_load) mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        len_q <= len_d;
                        pc_q  <= '0;
                        if (len_d != '0) begin
                            state_q <= RUN;
                            instr_q <= first_instr;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // stop wins over a same-cycle transfer; pc_out keeps the consumed address.
                    if (stop) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (xfer) begin
                        if (last) begin
`ifdef FETCH_LOOP_EN
                            pc_q    <= '0;
                            instr_q <= mem[0];
`else
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            pc_q    <= pc_d;
                            instr_q <= mem[pc_d];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch/issue stage directly upstream of integrated_datapath.
- Holds a small loadable program memory of 8-bit instructions (op = instr[7:6]: 00 ADD, 01 SUB, 10 AND, 11 OR).
- Issues the instructions in order over a valid/ready handshake.
- Replaces hand-driven instr stimulus and exposes its own program counter.

Parameters:
DEPTH, 16, number of program memory entries
ADDR_W, 4, address width; must equal clog2(DEPTH)
INSTR_W, 8, instruction width; matches datapath instr port

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_en  input  1  program memory write strobe
load_addr  input  ADDR_W  write address
load_data  input  INSTR_W  write data
prog_len  input  ADDR_W+1  number of instructions to issue, 0..DEPTH; sampled on start
start  input  1  begin issuing from address 0
stop  input  1  abort issue
instr_out  output  INSTR_W  current instruction to datapath
instr_valid  output  1  instr_out is valid
instr_ready  input  1  datapath accepts instr_out
pc_out  output  ADDR_W  address of instruction currently on instr_out
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Single clock domain; clk, async active-low rst_n.
- On rst_n low: state=IDLE; instr_out=0, instr_valid=0, pc_out=0, busy=0, done=0. Memory contents are not reset.
- States and transitions:
  - IDLE: load_en writes mem[load_addr]<=load_data. start with prog_len>0 goes to RUN; start with prog_len==0 goes to DONE.
  - RUN: load_en and start are ignored. instr_valid=1, busy=1.
  - DONE: done=1 (level), instr_valid=0. Loads are allowed. start behaves as in IDLE.
- Start: latch len=prog_len, pc=0, instr_out<=mem[0].
  - Latency: instr_valid rises exactly 1 cycle after the start edge.
  - Write-first bypass: if load_en && load_addr==0 on the start cycle, instr_out<=load_data.
- Transfer = instr_valid && instr_ready at a rising edge.
  - On transfer with pc<len-1: pc<=pc+1 and instr_out<=mem[pc+1]. Back-to-back issue is 1 instr/cycle.
  - On transfer with pc==len-1: state<=DONE, instr_valid<=0, pc_out holds its last value.
- Backpressure: while instr_valid && !instr_ready, instr_out and pc_out are held stable.
- stop in RUN: next edge goes to DONE and instr_valid drops. stop has priority over a simultaneous transfer; that transfer still counts as consumed but no further issue occurs. stop in IDLE/DONE is ignored.
- prog_len>DEPTH is clamped to DEPTH.
- rst_n asserted mid-RUN: immediate return to IDLE, all outputs 0. No partial issue resumes after reset.
- pc arithmetic: ADDR_W bits. When prog_len==DEPTH, pc reaches DEPTH-1 and does not wrap in base mode.

Optional Feature:
FETCH_LOOP_EN
- Defined: a transfer at pc==len-1 wraps pc to 0, loads instr_out<=mem[0] and stays in RUN. done is never asserted except via stop, which is the only exit from RUN besides reset.
- Undefined: behaviour exactly as specified above; the program terminates in DONE.

Test Plan:
- Load mem[0..3]=0x00,0x40,0x80,0xC0; prog_len=4; start; instr_ready=1 -> instr_out=0x00,0x40,0x80,0xC0 on 4 consecutive cycles with pc_out 0..3; instr_valid low and done=1 from the following cycle.
- Same program; instr_ready low for 3 cycles while pc_out=1 -> instr_out stays 0x40 and pc_out stays 1 for all 3 cycles; sequence then completes with no skip or repeat.
- prog_len=0; start -> done=1 the next cycle; instr_valid never asserts.
- Program of length 8 running; rst_n pulsed low while pc_out=3 -> all outputs 0 immediately. Then start again -> issue restarts at mem[0].
- Length-8 run; stop asserted together with a transfer at pc_out=2 -> instr_valid low the next cycle, done=1, pc_out=2. A load_en during RUN leaves the memory unchanged, confirmed on rerun.
- FETCH_LOOP_EN defined, prog_len=2 (0x40,0x80), ready=1 -> instr_out alternates 0x40,0x80 for 10 cycles; stop -> DONE.
